// File: rtl/memory_responder.sv
// Word-organised RAM with a 1-cycle instruction fetch port and a request/valid data port
// whose response arrives WAIT_STATES+1 cycles after acceptance; bad addresses fault, never wrap.
module memory_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instruction_address,
  output logic [31:0] o_instruction,
  output logic        o_instruction_fault,
  input  logic        i_data_request,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_write_data,
  input  logic        i_memory_write_enable,
  output logic [31:0] o_read_data,
  output logic        o_data_valid,
  output logic        o_data_fault,
  output logic        o_busy
);
  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] instr_q, instr_d;
  logic        ifault_q, ifault_d;
  logic [31:0] rdata_q, rdata_d;
  logic        dvld_q, dvld_d;
  logic        dfault_q, dfault_d;
  logic        busy_q, busy_d;

  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we, acc_fault, ifetch_fault, mem_we;
  logic [AW-1:0] acc_idx, ifetch_idx;

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
  endfunction

  // With zero wait states the commit happens on the capture edge, so use live inputs in IDLE.
  assign acc_addr     = (state_q == S_IDLE) ? i_data_address        : addr_q;
  assign acc_wdata    = (state_q == S_IDLE) ? i_write_data          : wdata_q;
  assign acc_we       = (state_q == S_IDLE) ? i_memory_write_enable : we_q;
  assign acc_fault    = addr_fault(acc_addr);
  assign acc_idx      = acc_addr[AW+1:2];
  assign ifetch_fault = addr_fault(i_instruction_address);
  assign ifetch_idx   = i_instruction_address[AW+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    dvld_d   = 1'b0;
    dfault_d = 1'b0;
    mem_we   = 1'b0;
    instr_d  = ifetch_fault ? NOP_WORD : mem[ifetch_idx];
    ifault_d = ifetch_fault;

    case (state_q)
      S_IDLE: begin
        if (i_data_request) begin
          addr_d  = i_data_address;
          wdata_d = i_write_data;
          we_d    = i_memory_write_enable;
          if (WAIT_STATES == 0) begin
            state_d = S_RESPOND;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESPOND;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // RESPOND always exits to IDLE, so a next state of RESPOND marks the commit edge.
    if (state_d == S_RESPOND) begin
      dvld_d   = 1'b1;
      dfault_d = acc_fault;
      mem_we   = acc_we && !acc_fault && !i_reset;
      if (acc_fault)   rdata_d = 32'd0;
      else if (acc_we) rdata_d = acc_wdata;
      else             rdata_d = mem[acc_idx];
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      instr_q  <= 32'd0;
      ifault_q <= 1'b0;
      rdata_q  <= 32'd0;
      dvld_q   <= 1'b0;
      dfault_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      instr_q  <= instr_d;
      ifault_q <= ifault_d;
      rdata_q  <= rdata_d;
      dvld_q   <= dvld_d;
      dfault_q <= dfault_d;
      busy_q   <= busy_d;
    end
  end

  // RAM contents survive reset; the fetch port reads the pre-write word on a collision.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  assign o_instruction       = instr_q;
  assign o_instruction_fault = ifault_q;
  assign o_read_data         = rdata_q;
  assign o_data_valid        = dvld_q;
  assign o_data_fault        = dfault_q;
  assign o_busy              = busy_q;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (1, 0 and 3 wait states) against a word-array model.
module tb_memory_responder;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [NI];
  logic [31:0] iaddr  [NI];
  logic [31:0] instr  [NI];
  logic        ifault [NI];
  logic        req    [NI];
  logic [31:0] daddr  [NI];
  logic [31:0] wdata  [NI];
  logic        we     [NI];
  logic [31:0] rdata  [NI];
  logic        dvld   [NI];
  logic        dfault [NI];
  logic        busy   [NI];

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [NI][1024];

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 1024 : 64;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    memory_responder #(
      .DEPTH_WORDS((g == 0) ? 1024 : 64),
      .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : 3),
      .NOP_WORD   (32'h00000013)
    ) u_dut (
      .i_clk                (clk),
      .i_reset              (rst[g]),
      .i_instruction_address(iaddr[g]),
      .o_instruction        (instr[g]),
      .o_instruction_fault  (ifault[g]),
      .i_data_request       (req[g]),
      .i_data_address       (daddr[g]),
      .i_write_data         (wdata[g]),
      .i_memory_write_enable(we[g]),
      .o_read_data          (rdata[g]),
      .o_data_valid         (dvld[g]),
      .o_data_fault         (dfault[g]),
      .o_busy               (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s obs=%h want=%h", tag, obs, want);
    end
  endtask

  function automatic logic is_fault(input int k, input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(depth_of(k)));
  endfunction

  function automatic logic [31:0] rand_addr(input int k);
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    a = 32'($urandom_range(0, depth_of(k) - 1)) << 2;
    if (r == 0)      a = a | 32'($urandom_range(1, 3));
    else if (r == 1) a = 32'(depth_of(k) * 4) + (32'($urandom_range(0, 255)) << 2);
    else if (r == 2) a = $urandom() | 32'h8000_0000;
    return a;
  endfunction

  // One data access: request held for one cycle, response timing and content checked.
  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic flt, busy1;
    logic [31:0] want_rd;
    int lat;
    flt     = is_fault(k, a);
    want_rd = flt ? 32'd0 : (w ? d : model[k][a[11:2]]);
    busy1   = 1'b0;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; daddr[k] = a; wdata[k] = d;
    lat = 0;
    do begin
      @(negedge clk);
      req[k] = 1'b0;
      lat++;
      if (lat == 1) busy1 = busy[k];
    end while (!dvld[k] && lat < 40);
    check("latency", lat, ws_of(k) + 1);
    check("busy_first", busy1, 1);
    check("busy_at_valid", busy[k], 1);
    check("read_data", rdata[k], want_rd);
    check("data_fault", dfault[k], flt);
    @(negedge clk);
    check("valid_drop", dvld[k], 0);
    check("busy_drop", busy[k], 0);
    if (w && !flt) model[k][a[11:2]] = d;
  endtask

  task automatic fetch(input int k, input logic [31:0] a);
    logic flt;
    logic [31:0] want;
    flt  = is_fault(k, a);
    want = flt ? 32'h00000013 : model[k][a[11:2]];
    @(negedge clk);
    iaddr[k] = a;
    @(negedge clk);
    check("instr", instr[k], want);
    check("instr_fault", ifault[k], flt);
  endtask

  initial begin
    int nv;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; iaddr[k] = 32'd0; req[k] = 1'b0;
      daddr[k] = 32'd0; wdata[k] = 32'd0; we[k] = 1'b0;
    end
    repeat (2) @(negedge clk);

    for (int k = 0; k < NI; k++) begin
      check("rst_instr", instr[k], 0);
      check("rst_ifault", ifault[k], 0);
      check("rst_rdata", rdata[k], 0);
      check("rst_valid", dvld[k], 0);
      check("rst_dfault", dfault[k], 0);
      check("rst_busy", busy[k], 0);
    end
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;

    for (int k = 0; k < NI; k++)
      for (int w = 0; w < depth_of(k); w++)
        access(k, 1'b1, 32'(w) << 2, $urandom());

    // Store then load with one wait state.
    access(0, 1'b1, 32'h10, 32'h12345678);
    access(0, 1'b0, 32'h10, 32'h0);

    // Faults: misaligned load, store just past the end, out-of-range fetches.
    access(0, 1'b0, 32'h6, 32'h0);
    access(0, 1'b1, 32'h1000, 32'h55AA55AA);
    access(0, 1'b0, 32'h0, 32'h0);
    fetch(0, 32'h1000);
    fetch(0, 32'h2);
    fetch(0, 32'hFFFF_FFFC);

    // Collision: fetch sees the old word on the commit edge, the new one next cycle.
    access(0, 1'b1, 32'h20, 32'h11111111);
    fetch(0, 32'h20);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; daddr[0] = 32'h20; wdata[0] = 32'hAAAA5555;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    check("coll_valid", dvld[0], 1);
    check("coll_old", instr[0], 32'h11111111);
    @(negedge clk);
    check("coll_new", instr[0], 32'hAAAA5555);
    model[0][8] = 32'hAAAA5555;

    // Zero wait states, then a held request responds every second cycle.
    access(1, 1'b1, 32'h0, 32'hCAFEF00D);
    access(1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; daddr[1] = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("held_valid", dvld[1], 32'(i % 2));
      if (i % 2 == 1) check("held_data", rdata[1], 32'hCAFEF00D);
    end
    req[1] = 1'b0;
    @(negedge clk);

    // Reset two cycles into a store with three wait states: nothing commits.
    access(2, 1'b1, 32'h40, 32'h0);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; daddr[2] = 32'h40; wdata[2] = 32'hDEADBEEF;
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    check("rst_mid_busy", busy[2], 0);
    check("rst_mid_valid", dvld[2], 0);
    @(negedge clk);
    rst[2] = 1'b0;
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      nv += int'(dvld[2]);
    end
    check("rst_mid_no_valid", nv, 0);
    access(2, 1'b0, 32'h40, 32'h0);

    // A request pulsed during WAIT is ignored; the first address is answered once.
    access(2, 1'b1, 32'h80, 32'h0BADF00D);
    access(2, 1'b1, 32'h84, 32'h600DCAFE);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; daddr[2] = 32'h80;
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    req[2] = 1'b1; daddr[2] = 32'h84;
    nv = 0;
    for (int i = 3; i <= 12; i++) begin
      @(negedge clk);
      req[2] = 1'b0;
      if (dvld[2]) begin
        nv++;
        check("busy_req_data", rdata[2], 32'h0BADF00D);
        check("busy_req_latency", i, 4);
      end
    end
    check("busy_req_count", nv, 1);

    // Randomised traffic on every instance.
    for (int k = 0; k < NI; k++) begin
      repeat (60) access(k, 1'($urandom_range(0, 1)), rand_addr(k), $urandom());
      repeat (40) fetch(k, rand_addr(k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
